div_sig_pipe_ctrl: RTL
======================

Name: div_sig_pipe_ctrl

Overview:
- Flow controller for the pipelined radix-4 significand divider (div_sigcalc, PIPE_STAGES 0..3).
- Accepts operand requests over a valid/ready handshake and drives the divider's global enable. Tracks in-flight valid bits and sideband (tag, sign/exponent/special flags) in lock-step with the divider's register stages.
- Captures results into a 2-entry output skid buffer, presented over a valid/ready handshake to the rounding/normalisation stage.

Parameters:
- SIG_WIDTH, 23, significand fraction width; divider operands and quotient are SIG_WIDTH+1 bits.
- PIPE_STAGES, 0, divider register-stage count NREG (0..3); must equal the divider instance's pipe_stages.
- TAG_W, 4, request tag width.
- SIDE_W, 12, opaque sideband width (sign, exponent, special-case flags).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all in-flight and buffered work.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_tag  in  TAG_W  request tag.
- in_side  in  SIDE_W  request sideband.
- dp_enable  out  1  divider enable.
- dp_resetn  out  1  divider reset, equal to !reset.
- dp_quotient  in  SIG_WIDTH+1  divider quotient.
- dp_guard, dp_round, dp_sticky, dp_count  in  1 each  divider rounding bits and normalisation flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_quotient  out  SIG_WIDTH+1  result quotient.
- out_guard, out_round, out_sticky, out_count  out  1 each  result bits.
- out_tag  out  TAG_W  result tag.
- out_side  out  SIDE_W  result sideband.
- busy  out  1  any valid stage or buffered entry.

Behaviour:
- Reset: all valid bits, skid entries, tag/side shift registers = 0. Outputs: out_valid=0, in_ready=0, busy=0, dp_enable=0, out_* data=0.
- Per-stage state: vld[k], tag[k], side[k] for k=1..NREG, matching the divider's register stages in order.
- skid_cnt ∈ {0,1,2}: entries held in the skid buffer.
- Global stall: dp_enable = !reset && !flush && !(vld_last && skid_cnt==2 && !out_ready).
  - vld_last = vld[NREG] for NREG>0; = in_valid for NREG=0.
  - The divider freezes as a whole; no bubble collapse.
- in_ready = dp_enable.
- On dp_enable:
  - vld[1] <= in_valid, vld[k] <= vld[k-1].
  - tag/side shift alongside vld.
- Result capture: when dp_enable && vld_last, push {dp_* , tag, side} into the skid buffer.
  - Latency in→out_valid = NREG+1 cycles with no backpressure.
  - Throughput is 1 per cycle.
- Skid buffer: 2-entry FIFO; entry 0 drives out_*; out_valid = skid_cnt!=0.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop at cnt=2: legal, cnt stays 2.
  - At cnt=1: cnt stays 1 and data advances.
- Flush: next cycle all vld=0, skid_cnt=0, out_valid=0.
  - A request offered with flush is not accepted (in_ready=0).
  - The divider's own datapath registers are not cleared; their content is ignored because vld=0.
- Reset mid-operation: identical to flush, plus dp_resetn asserts low for the cycle.
- busy = |vld || skid_cnt!=0.
- out_* data holds its value while out_valid && !out_ready.

Optional Feature:
- DIV_CTRL_PERF_EN.
- Defined: adds outputs perf_issued[31:0] (accepted requests), perf_stall[31:0] (cycles with !dp_enable && busy) and perf_retired[31:0] (pops).
  - Counters clear on reset only, not on flush, and saturate at 2^32-1.
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package div_ctrl_pkg holds:
  - typedef div_res_t {quotient, guard, round, sticky, count} parameterised by SIG_WIDTH via localparam;
  - localparam MAX_PIPE_STAGES=3.
- One sub-module, div_skid_buf (2-entry valid/ready buffer of div_res_t+tag+side), reusable by the sqrt controller.

Test Plan (SIG_WIDTH=23, divider instantiated, PIPE_STAGES swept 0..3):
- Single op x=24'h800000, d=24'h800000, tag=3 → out_valid after PIPE_STAGES+1 cycles; quotient 24'h800000, count=0, G/R/S=0, tag=3.
- x=24'h800000, d=24'hC00000 → quotient 24'hAAAAAA, count=1, guard=1, round=0, sticky=1.
- 8 back-to-back ops with out_ready=1, tags 0..7 → one result per cycle, in order, zero stall cycles.
- out_ready=0 for 6 cycles during a stream (PIPE_STAGES=3) → skid fills to 2, dp_enable=0, in_ready=0; no loss or duplication; order preserved after release.
- flush asserted with 3 ops in flight and 1 buffered → next cycle out_valid=0, busy=0; subsequent op returns the correct result with its own tag.
- reset asserted mid-stream → all outputs 0 next cycle; with DIV_CTRL_PERF_EN defined, counters read 0 and after 5 ops perf_issued=5, perf_retired=5.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and limits for the divider/sqrt flow controllers.
//   div_res_t       : one divider result (quotient plus rounding/normalisation bits)
//   DIV_SIG_WIDTH   : significand fraction width the result type is built for
//   MAX_PIPE_STAGES : largest supported divider register-stage count
package div_ctrl_pkg;

   localparam int DIV_SIG_WIDTH   = 23;
   localparam int MAX_PIPE_STAGES = 3;

   typedef struct packed {
      logic [DIV_SIG_WIDTH:0] quotient;
      logic                   guard;
      logic                   round;
      logic                   sticky;
      logic                   count;
   } div_res_t;

endpackage

// File: rtl/div_skid_buf.sv
// Two-entry valid/ready output buffer holding a div_res_t with its tag and
// sideband. Entry 0 always drives the outputs.
//   clk, reset        : clock, synchronous active-high reset (clears data too)
//   flush             : synchronous discard of buffered entries
//   push, push_*      : write one entry (ignored when full and not popping)
//   pop_ready         : consumer ready; a pop happens on out_valid && pop_ready
//   out_valid, out_*  : head entry
//   cnt               : occupancy 0..2
module div_skid_buf
   import div_ctrl_pkg::*;
#(
   parameter int TAG_W  = 4,
   parameter int SIDE_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  div_res_t          push_res,
   input  logic [TAG_W-1:0]  push_tag,
   input  logic [SIDE_W-1:0] push_side,
   input  logic              pop_ready,
   output logic              out_valid,
   output div_res_t          out_res,
   output logic [TAG_W-1:0]  out_tag,
   output logic [SIDE_W-1:0] out_side,
   output logic [1:0]        cnt
);

   localparam int ENT_W = $bits(div_res_t) + TAG_W + SIDE_W;

   logic [ENT_W-1:0] ent0, ent1, din;
   logic             pop, wr;

   assign din       = {push_res, push_tag, push_side};
   assign out_valid = (cnt != 2'd0);
   assign pop       = out_valid && pop_ready;
   // A full buffer only takes a new entry when the head leaves in the same cycle.
   assign wr        = push && ((cnt != 2'd2) || pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= 2'd0;
         ent0 <= '0;
         ent1 <= '0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         case ({wr, pop})
            2'b10: begin
               if (cnt == 2'd0) ent0 <= din;
               else             ent1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; at one entry the new result becomes the head.
               if (cnt == 2'd1) begin
                  ent0 <= din;
               end else begin
                  ent0 <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign {out_res, out_tag, out_side} = ent0;

endmodule

// File: rtl/div_sig_pipe_ctrl.sv
// Flow controller for the pipelined radix-4 significand divider. Accepts
// requests over valid/ready, drives the divider's global enable, carries valid
// bits and tag/sideband in step with the divider's register stages and
// captures results into a two-entry skid buffer for the rounding stage.
//   clk, reset, flush        : clock, sync active-high reset, sync discard
//   in_valid/in_ready/in_*   : request handshake with tag and sideband
//   dp_enable, dp_resetn     : divider enable and active-low reset
//   dp_quotient, dp_guard..  : divider result inputs
//   out_valid/out_ready/out_*: result handshake
//   busy                     : any stage valid or entry buffered
// Optional build macro DIV_CTRL_PERF_EN adds perf_issued, perf_stall and
// perf_retired saturating counters (cleared by reset only).
// SIG_WIDTH must match div_ctrl_pkg::DIV_SIG_WIDTH; PIPE_STAGES must match the
// divider instance and not exceed MAX_PIPE_STAGES.
module div_sig_pipe_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int SIG_WIDTH   = 23,
   parameter int PIPE_STAGES = 0,
   parameter int TAG_W       = 4,
   parameter int SIDE_W      = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [TAG_W-1:0]     in_tag,
   input  logic [SIDE_W-1:0]    in_side,
   output logic                 dp_enable,
   output logic                 dp_resetn,
   input  logic [SIG_WIDTH:0]   dp_quotient,
   input  logic                 dp_guard,
   input  logic                 dp_round,
   input  logic                 dp_sticky,
   input  logic                 dp_count,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SIG_WIDTH:0]   out_quotient,
   output logic                 out_guard,
   output logic                 out_round,
   output logic                 out_sticky,
   output logic                 out_count,
   output logic [TAG_W-1:0]     out_tag,
   output logic [SIDE_W-1:0]    out_side,
   output logic                 busy
`ifdef DIV_CTRL_PERF_EN
   ,
   output logic [31:0]          perf_issued,
   output logic [31:0]          perf_stall,
   output logic [31:0]          perf_retired
`endif
);

   localparam int NREG = PIPE_STAGES;

   logic              vld_last, vld_any, push;
   logic [TAG_W-1:0]  tag_last;
   logic [SIDE_W-1:0] side_last;
   logic [1:0]        skid_cnt;
   div_res_t          push_res, out_res;

   // The whole divider freezes when a result is ready to leave but the skid
   // buffer is full and the consumer is not taking its head.
   assign dp_enable = !reset && !flush && !(vld_last && (skid_cnt == 2'd2) && !out_ready);
   assign in_ready  = dp_enable;
   assign dp_resetn = !reset;
   assign push      = dp_enable && vld_last;
   assign busy      = vld_any || (skid_cnt != 2'd0);

   generate
      if (NREG == 0) begin : g_comb
         // Combinational divider: the result belongs to the request offered now.
         assign vld_last  = in_valid;
         assign tag_last  = in_tag;
         assign side_last = in_side;
         assign vld_any   = 1'b0;
      end else begin : g_pipe
         logic [NREG:1]     vld_p;
         logic [TAG_W-1:0]  tag_p  [1:NREG];
         logic [SIDE_W-1:0] side_p [1:NREG];

         // Stage k mirrors divider register stage k
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_p <= '0;
               for (int k = 1; k <= NREG; k++) begin
                  tag_p[k]  <= '0;
                  side_p[k] <= '0;
               end
            end else if (flush) begin
               vld_p <= '0;
            end else if (dp_enable) begin
               vld_p[1]  <= in_valid;
               tag_p[1]  <= in_tag;
               side_p[1] <= in_side;
               for (int k = 2; k <= NREG; k++) begin
                  vld_p[k]  <= vld_p[k-1];
                  tag_p[k]  <= tag_p[k-1];
                  side_p[k] <= side_p[k-1];
               end
            end
         end

         assign vld_last  = vld_p[NREG];
         assign tag_last  = tag_p[NREG];
         assign side_last = side_p[NREG];
         assign vld_any   = |vld_p;
      end
   endgenerate

   always_comb begin
      push_res          = '0;
      push_res.quotient = dp_quotient;
      push_res.guard    = dp_guard;
      push_res.round    = dp_round;
      push_res.sticky   = dp_sticky;
      push_res.count    = dp_count;
   end

   // Result capture boundary
   div_skid_buf #(
      .TAG_W  (TAG_W),
      .SIDE_W (SIDE_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push),
      .push_res  (push_res),
      .push_tag  (tag_last),
      .push_side (side_last),
      .pop_ready (out_ready),
      .out_valid (out_valid),
      .out_res   (out_res),
      .out_tag   (out_tag),
      .out_side  (out_side),
      .cnt       (skid_cnt)
   );

   assign out_quotient = out_res.quotient;
   assign out_guard    = out_res.guard;
   assign out_round    = out_res.round;
   assign out_sticky   = out_res.sticky;
   assign out_count    = out_res.count;

`ifdef DIV_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issued  <= '0;
         perf_stall   <= '0;
         perf_retired <= '0;
      end else begin
         if (in_valid && in_ready && (perf_issued != '1))
            perf_issued <= perf_issued + 32'd1;
         if (!dp_enable && busy && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
         if (out_valid && out_ready && (perf_retired != '1))
            perf_retired <= perf_retired + 32'd1;
      end
   end
`endif

endmodule
